// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver: error codes, deframer states and parity modes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'b000,
    ERR_PARITY  = 3'b001,
    ERR_FRAME   = 3'b010,
    ERR_TIMEOUT = 3'b100
  } err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead synchronous FIFO holding {error, data} entries.
// A push into a full FIFO with no pop is dropped and raises a sticky overflow flag.
module ps2_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   ovf_clr,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_next;

  assign head = mem[rd_ptr];

  // Accepted push/pop and the resulting occupancy
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_ONE;
    end else begin
      count_next = count;
    end
  end

  // Storage, pointers and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_FULL);
      // A drop takes priority over a coincident clear
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the PS/2 clock, deframes
// start/data/parity/stop with an inter-edge timeout, and queues {error,data} entries.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 1,
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CLK_PS2_IN,
  input  logic                        DATA_PS2_IN,
  input  logic                        READ_ENABLE,
  input  logic                        POP,
  input  logic                        OVF_CLR,
  output logic [DATA_BITS-1:0]        BYTE_OUT,
  output logic [2:0]                  ERR_OUT,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic [$clog2(FIFO_DEPTH):0] COUNT,
  output logic                        OVERFLOW
);

  localparam int W  = DATA_BITS + 3;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    case (PARITY_MODE)
      PARITY_ODD:  return ((^d) ^ p) != 1'b1;
      PARITY_EVEN: return ((^d) ^ p) != 1'b0;
      default:     return 1'b0;
    endcase
  endfunction

  logic [1:0]           sync_clk;
  logic [1:0]           sync_data;
  logic                 filt_clk;
  logic [FW-1:0]        filt_cnt;
  logic                 filt_flip;
  logic                 fall;
  state_t               state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [TW-1:0]        tmo_cnt;
  logic                 push;
  logic [W-1:0]         push_entry;
  logic [2:0]           err_code;
  logic [W-1:0]         head;

  // Two-flop synchronisers for both PS/2 lines
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_clk  <= 2'b11;
      sync_data <= 2'b11;
    end else begin
      sync_clk  <= {sync_clk[0], CLK_PS2_IN};
      sync_data <= {sync_data[0], DATA_PS2_IN};
    end
  end

  // Filter flip condition, falling-edge pulse and error code of the frame ending now
  always_comb begin
    filt_flip = (sync_clk[1] != filt_clk) && (filt_cnt == FILT_LAST);
    fall      = filt_flip && filt_clk;
    err_code  = (sync_data[1] ? ERR_NONE : ERR_FRAME) |
                (parity_error(shreg, par_bit) ? ERR_PARITY : ERR_NONE);
  end

  // Clock filter: count consecutive samples that disagree with the accepted level
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (sync_clk[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= sync_clk[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Deframer FSM with inter-edge timeout; the entry is pushed the cycle after the stop fall
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      push       <= 1'b0;
      push_entry <= '0;
    end else begin
      push <= 1'b0;
      if (!READ_ENABLE) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else if (state != IDLE && !fall && tmo_cnt == TMO_LAST) begin
        state      <= IDLE;
        tmo_cnt    <= '0;
        push       <= 1'b1;
        push_entry <= {ERR_TIMEOUT, {DATA_BITS{1'b0}}};
      end else if (fall) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!sync_data[1]) begin
              state   <= DATA;
              bit_cnt <= 4'd0;
            end
          end
          DATA: begin
            shreg   <= {sync_data[1], shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
            end
          end
          PARITY: begin
            par_bit <= sync_data[1];
            state   <= STOP;
          end
          STOP: begin
            push       <= 1'b1;
            push_entry <= {err_code, shreg};
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  ps2_rx_fifo #(
    .WIDTH(W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (push),
    .push_data(push_entry),
    .pop      (POP),
    .ovf_clr  (OVF_CLR),
    .head     (head),
    .empty    (EMPTY),
    .full     (FULL),
    .count    (COUNT),
    .overflow (OVERFLOW)
  );

  assign BYTE_OUT = head[DATA_BITS-1:0];
  assign ERR_OUT  = head[W-1 -: 3];

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench: an 8-bit odd-parity receiver (depth 4) and a 7-bit no-parity receiver,
// PS/2 clock at 10 kHz against a 1 MHz system clock.
`timescale 1ns/1ps
module tb_ps2_frame_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_a, dat_a, clk_b, dat_b;
  logic       read_enable, pop_a, pop_b, ovf_clr;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic [2:0] err_a, err_b, count_a, count_b;
  logic       empty_a, full_a, ovf_a, empty_b, full_b, ovf_b;
  bit         sel;
  int         checks = 0;
  int         failures = 0;

  always #500 clk = ~clk;

  ps2_frame_receiver #(
    .DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(4), .FILTER_CYCLES(4), .TIMEOUT_CYCLES(200)
  ) dut_a (
    .CLK(clk), .RESET(rst), .CLK_PS2_IN(clk_a), .DATA_PS2_IN(dat_a),
    .READ_ENABLE(read_enable), .POP(pop_a), .OVF_CLR(ovf_clr),
    .BYTE_OUT(byte_a), .ERR_OUT(err_a), .EMPTY(empty_a), .FULL(full_a),
    .COUNT(count_a), .OVERFLOW(ovf_a)
  );

  ps2_frame_receiver #(
    .DATA_BITS(7), .PARITY_MODE(0), .FIFO_DEPTH(4), .FILTER_CYCLES(4), .TIMEOUT_CYCLES(200)
  ) dut_b (
    .CLK(clk), .RESET(rst), .CLK_PS2_IN(clk_b), .DATA_PS2_IN(dat_b),
    .READ_ENABLE(read_enable), .POP(pop_b), .OVF_CLR(ovf_clr),
    .BYTE_OUT(byte_b), .ERR_OUT(err_b), .EMPTY(empty_b), .FULL(full_b),
    .COUNT(count_b), .OVERFLOW(ovf_b)
  );

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input logic c, input logic d);
    if (sel) begin
      clk_b = c;
      dat_b = d;
    end else begin
      clk_a = c;
      dat_a = d;
    end
  endtask

  task automatic ps2_bit(input logic d);
    drv(1'b1, d);
    wait_cycles(25);
    drv(1'b0, d);
    wait_cycles(50);
    drv(1'b1, d);
    wait_cycles(25);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                            input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < nb; i++) ps2_bit(d[i]);
    if (has_par) ps2_bit(par);
    ps2_bit(stop);
    drv(1'b1, 1'b1);
    wait_cycles(20);
  endtask

  task automatic do_pop_a;
    @(negedge clk) pop_a = 1'b1;
    @(negedge clk) pop_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clk_a = 1'b1; dat_a = 1'b1; clk_b = 1'b1; dat_b = 1'b1;
    read_enable = 1'b1; pop_a = 1'b0; pop_b = 1'b0; ovf_clr = 1'b0;
    sel = 1'b0;
    wait_cycles(5);
    check("rst_byte", byte_a, 8'h00);
    check("rst_err", err_a, 3'b000);
    check("rst_empty", empty_a, 1'b1);
    check("rst_full", full_a, 1'b0);
    check("rst_count", count_a, 3'd0);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_empty_b", empty_b, 1'b1);
    rst = 1'b0;
    wait_cycles(10);

    // good odd-parity frame
    send_frame(9'h0A5, 8, 1'b1, 1'b1, 1'b1);
    check("t1_empty", empty_a, 1'b0);
    check("t1_count", count_a, 3'd1);
    check("t1_byte", byte_a, 8'hA5);
    check("t1_err", err_a, 3'b000);
    do_pop_a();
    check("t1_empty_after_pop", empty_a, 1'b1);

    // 0x3C has four ones, so parity bit 0 is wrong for odd parity; stop bit 0
    send_frame(9'h03C, 8, 1'b1, 1'b0, 1'b0);
    check("t2_byte", byte_a, 8'h3C);
    check("t2_err", err_a, 3'b011);
    do_pop_a();

    // clock stalls after four data bits
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    drv(1'b1, 1'b1);
    wait_cycles(100);
    check("t3_no_early_timeout", empty_a, 1'b1);
    wait_cycles(160);
    check("t3_count", count_a, 3'd1);
    check("t3_byte", byte_a, 8'h00);
    check("t3_err", err_a, 3'b100);
    do_pop_a();
    send_frame(9'h012, 8, 1'b1, odd_par(8'h12), 1'b1);
    check("t3_next_byte", byte_a, 8'h12);
    check("t3_next_err", err_a, 3'b000);
    check("t3_next_count", count_a, 3'd1);
    do_pop_a();

    // five frames into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) send_frame(9'(i), 8, 1'b1, odd_par(8'(i)), 1'b1);
    check("t4_full", full_a, 1'b1);
    check("t4_count", count_a, 3'd4);
    check("t4_ovf", ovf_a, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("t4_pop_byte", byte_a, 32'(i));
      check("t4_pop_err", err_a, 3'b000);
      do_pop_a();
    end
    check("t4_empty", empty_a, 1'b1);
    check("t4_ovf_sticky", ovf_a, 1'b1);
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf_a, 1'b0);

    // 2-cycle clock glitch with data low must not start a frame
    drv(1'b1, 1'b0);
    wait_cycles(10);
    drv(1'b0, 1'b0);
    wait_cycles(2);
    drv(1'b1, 1'b0);
    wait_cycles(20);
    drv(1'b1, 1'b1);
    wait_cycles(300);
    check("t5_glitch_empty", empty_a, 1'b1);

    // READ_ENABLE dropped mid-frame discards the partial frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk) read_enable = 1'b0;
    wait_cycles(10);
    read_enable = 1'b1;
    drv(1'b1, 1'b1);
    wait_cycles(300);
    check("t5_abort_empty", empty_a, 1'b1);
    send_frame(9'h05A, 8, 1'b1, odd_par(8'h5A), 1'b1);
    check("t5_clean_count", count_a, 3'd1);
    check("t5_clean_byte", byte_a, 8'h5A);
    check("t5_clean_err", err_a, 3'b000);
    do_pop_a();

    // asynchronous reset mid-frame with three entries queued
    send_frame(9'h011, 8, 1'b1, odd_par(8'h11), 1'b1);
    send_frame(9'h022, 8, 1'b1, odd_par(8'h22), 1'b1);
    send_frame(9'h033, 8, 1'b1, odd_par(8'h33), 1'b1);
    check("t6_count3", count_a, 3'd3);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    #200;
    rst = 1'b1;
    #1;
    check("t6_rst_empty", empty_a, 1'b1);
    check("t6_rst_count", count_a, 3'd0);
    check("t6_rst_ovf", ovf_a, 1'b0);
    check("t6_rst_byte", byte_a, 8'h00);
    drv(1'b1, 1'b1);
    wait_cycles(10);
    rst = 1'b0;
    wait_cycles(10);

    // 7-bit frame without parity on the second receiver
    sel = 1'b1;
    send_frame(9'h055, 7, 1'b0, 1'b0, 1'b1);
    check("t6_b_count", count_b, 3'd1);
    check("t6_b_byte", byte_b, 7'h55);
    check("t6_b_err", err_b, 3'b000);
    check("t6_a_untouched", empty_a, 1'b1);
    @(negedge clk) pop_b = 1'b1;
    @(negedge clk) pop_b = 1'b0;
    check("t6_b_empty", empty_b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
